// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - walks every minterm, samples two implementations, compares against a golden truth table
module truth_table_checker #(
  parameter int                 N_IN   = 2,
  parameter logic [2**N_IN-1:0] TRUTH  = 4'b0010,
  parameter int                 SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_a,
  input  logic              s_b,
  output logic [N_IN-1:0]   x,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     mismatch_cnt,
  output logic [N_IN-1:0]   first_fail,
  output logic              fail_valid,
  output logic              err_a,
  output logic              err_b
);

  // Wait counter only needs to reach SETTLE-1; keep at least one bit.
  localparam int              W_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [W_W-1:0]  W_LAST = W_W'(SETTLE - 1);
  localparam logic [N_IN-1:0] M_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state;
  logic [N_IN-1:0] m;
  logic [W_W-1:0]  w;

  logic expected;
  logic bad_a;
  logic bad_b;
  logic bad;

  // Golden value for the current minterm and per-implementation disagreement.
  always_comb begin
    expected = TRUTH[m];
    bad_a    = (s_a != expected);
    bad_b    = (s_b != expected);
    bad      = bad_a | bad_b;
  end

  // Run sequencer: applies each minterm, lets it settle, samples once, records results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      m            <= '0;
      w            <= '0;
      x            <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
      fail_valid   <= 1'b0;
      err_a        <= 1'b0;
      err_b        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A restart from DONE is indistinguishable from a start from IDLE.
          if (start) begin
            state        <= APPLY;
            m            <= '0;
            w            <= '0;
            x            <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            fail_valid   <= 1'b0;
            err_a        <= 1'b0;
            err_b        <= 1'b0;
          end
        end

        APPLY: begin
          if (w == W_LAST) begin
            state <= SAMPLE;
          end else begin
            w <= w + W_W'(1);
          end
        end

        SAMPLE: begin
          // One count per minterm even when both implementations disagree.
          if (bad) begin
            mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
            if (!fail_valid) begin
              first_fail <= m;
              fail_valid <= 1'b1;
            end
          end
          if (bad_a) err_a <= 1'b1;
          if (bad_b) err_b <= 1'b1;

          if (m == M_LAST) begin
            // Final sample must count toward pass, so fold it in directly.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (mismatch_cnt == '0) && !bad;
          end else begin
            state <= APPLY;
            m     <= m + N_IN'(1);
            x     <= m + N_IN'(1);
            w     <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - scoreboard bench for truth_table_checker with randomized faulty implementations
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       s_a;
  logic       s_b;
  logic [1:0] x;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] mismatch_cnt;
  logic [1:0] first_fail;
  logic       fail_valid;
  logic       err_a;
  logic       err_b;

  // Per-minterm fault masks: a set bit inverts that implementation's output for that minterm.
  logic [3:0] fa = 4'b0;
  logic [3:0] fb = 4'b0;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  logic done_q = 1'b0;

  typedef struct {
    int cnt;
    int first;
    int fv;
    int ea;
    int eb;
    int ps;
    int dcyc;
  } exp_t;

  exp_t q[$];
  exp_t e;

  truth_table_checker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .s_a          (s_a),
    .s_b          (s_b),
    .x            (x),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .mismatch_cnt (mismatch_cnt),
    .first_fail   (first_fail),
    .fail_valid   (fail_valid),
    .err_a        (err_a),
    .err_b        (err_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The function under test is s = a'.b with a = x[1], b = x[0].
  function automatic logic golden(input logic [1:0] v);
    return ~v[1] & v[0];
  endfunction

  assign s_a = golden(x) ^ fa[x];
  assign s_b = golden(x) ^ fb[x];

  task automatic check(input string name, input int act, input int req);
    chk_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Reference model: results are a direct function of which minterms were faulted.
  function automatic exp_t model(input logic [3:0] ma, input logic [3:0] mb, input int dcyc);
    exp_t r;
    r.cnt   = 0;
    r.first = 0;
    r.fv    = 0;
    r.ea    = (ma != 0) ? 1 : 0;
    r.eb    = (mb != 0) ? 1 : 0;
    for (int k = 3; k >= 0; k--) begin
      if (ma[k] | mb[k]) begin
        r.cnt++;
        r.first = k;
        r.fv    = 1;
      end
    end
    r.ps   = (r.cnt == 0) ? 1 : 0;
    r.dcyc = dcyc;
    return r;
  endfunction

  // Monitor: pops one expectation per rising done and compares every result field.
  always @(negedge clk) begin
    if (rst_n && done && !done_q) begin
      if (q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_done: done rose with no run queued");
      end else begin
        e = q.pop_front();
        check("mismatch_cnt", int'(mismatch_cnt), e.cnt);
        check("fail_valid",   int'(fail_valid),   e.fv);
        if (e.fv != 0) check("first_fail", int'(first_fail), e.first);
        check("err_a",        int'(err_a),        e.ea);
        check("err_b",        int'(err_b),        e.eb);
        check("pass",         int'(pass),         e.ps);
        check("done_latency", cyc,                e.dcyc);
      end
    end
    done_q <= done;
  end

  task automatic run(input logic [3:0] ma, input logic [3:0] mb, input bit hold);
    int t;
    @(negedge clk);
    fa    = ma;
    fb    = mb;
    start = 1'b1;
    @(negedge clk);
    q.push_back(model(ma, mb, cyc + 8));
    if (!hold) start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("x_walk", int'(x), k >> 1);
      check("busy_run", int'(busy), 1);
      @(negedge clk);
    end
    t = 0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("done_timeout", int'(done), 1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("done_held", int'(done), 1);
    check("x_hold_last", int'(x), 3);
    check("busy_idle", int'(busy), 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_x"},    int'(x), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_cnt"},  int'(mismatch_cnt), 0);
    check({tag, "_fv"},   int'(fail_valid), 0);
    check({tag, "_ff"},   int'(first_fail), 0);
    check({tag, "_ea"},   int'(err_a), 0);
    check({tag, "_eb"},   int'(err_b), 0);
  endtask

  initial begin
    int t;
    int seen;
    logic [3:0] ra;
    logic [3:0] rb;

    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    run(4'b0000, 4'b0000, 1'b0);
    run(4'b0000, 4'b0010, 1'b0);
    run(4'b1111, 4'b0000, 1'b0);
    run(4'b0110, 4'b1000, 1'b1);
    run(4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom());
      rb = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom());
      run(ra, rb, ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a run that has already recorded a mismatch at m = 1.
    @(negedge clk);
    fa    = 4'b0000;
    fb    = 4'b0010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (x != 2'd2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("reach_x2", int'(x), 2);
    check("midrun_fv", int'(fail_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_cleared("midreset");
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("no_done_after_reset", seen, 0);
    check("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
